uart_rx_ext: RTL
================

# uart_rx_ext

Parametrised UART receiver, next generation of the team's single-frame receiver. It synchronises the serial line, detects and qualifies start bits, and samples a configurable number of data bits (LSB first). It then checks optional parity and 1 or 2 stop bits. Each character is delivered on a valid/ready output with per-character parity and framing error flags and a sticky-free overrun pulse. It sits between the board RX pin and the command/FIFO logic.

## Interface
- CLK_FREQ, 50_000_000, clock frequency in Hz
- BAUD_RATE, 9600, line rate; CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division), legal range 8..65535
- DATA_BITS, 8, data bits per character, 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- rx_data  output  DATA_BITS  received character, valid while rx_valid=1
- rx_valid  output  1  character available; held until accepted
- rx_ready  input  1  consumer accepts rx_data when rx_valid && rx_ready
- rx_parity_err  output  1  parity mismatch for the character in rx_data (0 when PARITY=0)
- rx_frame_err  output  1  at least one stop bit sampled low for the character in rx_data
- rx_overrun  output  1  one-cycle pulse: a completed character was dropped
- rx_busy  output  1  frame reception in progress

## Operation
- Input: 2-flop synchroniser on rx (both flops reset to 1); the FSM sees rx_s only.
- Bit counter: 16 bits, runs 0..CLKS_PER_BIT-1, then wraps to 0 and advances to the next bit. MID = CLKS_PER_BIT/2. Decision point D = MID (MID+1 with majority, see Configuration).
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: the cycle that sees rx_s=0 is count 0 of the start bit; go to START, rx_busy=1.
- START: at count D, if the bit is 0, continue (bit_idx=0). If it is 1, it is a false start: return to IDLE. No flags change and rx_busy falls.
- DATA: at D of each bit, shift the decided value into position bit_idx. After DATA_BITS bits, go to PARITY, or to STOP when PARITY=0.
- PARITY: at D, compare the decided bit against the computed parity. Odd: XOR(data, bit)=1. Even: XOR(data, bit)=0. Mismatch sets the pending parity error.
- STOP: at D of each stop bit, a 0 sets the pending framing error. At D of the last stop bit, complete the character and go to IDLE in the same edge. This allows back-to-back start detection.
- Completion (one cycle after the last decision):
  - rx_valid=0, or rx_ready=1 in the completion cycle: load rx_data and both error flags, rx_valid=1.
  - rx_valid=1 and rx_ready=0: the new character is discarded, the old one is retained, and rx_overrun pulses for 1 cycle.
- Acceptance: when rx_valid && rx_ready and no completion occurs in that cycle, rx_valid falls on the next edge.
- Frames with errors are still delivered. The consumer decides what to do with them.

## Timing
- Reset: rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, FSM=IDLE, sync flops=1. Reset mid-frame discards the partial frame with no outputs.
- Latency is measured from the rx falling edge at the pin to rx_valid rising: 2 + (DATA_BITS + P + STOP_BITS)*CLKS_PER_BIT + D + 1 cycles, with P = (PARITY != 0).
- rx_busy is high from START entry to the IDLE return, inclusive of the completion edge only.
- rx_valid/rx_data/flags change only on completion or acceptance. rx_ready is ignored when rx_valid=0.

## Configuration
- UART_RX_MAJORITY_EN
  - Defined: each bit decision is the 2-of-3 majority of rx_s sampled at counts MID-1, MID and MID+1, with D=MID+1. This rejects single-cycle glitches.
  - Undefined: each bit decision is the single rx_s sample at count MID, with D=MID. The sampling registers are absent.

## Test plan
All scenarios use CLK_FREQ=1_000_000 and BAUD_RATE=100_000 (CLKS_PER_BIT=10, MID=5).
- 8N1, send 0xA5, rx_ready=0 -> rx_valid=1 at the latency formula value, rx_data=0xA5, both errors 0, held until rx_ready=1, then falls the next cycle.
- PARITY=2, send 0x37 with parity bit 0 (wrong) -> rx_data=0x37, rx_parity_err=1. Resend with parity bit 1 -> rx_parity_err=0.
- 8N1, send 0x5A with the stop bit held low -> rx_data=0x5A, rx_frame_err=1. STOP_BITS=2 with the second stop bit low -> rx_frame_err=1.
- rx low pulse of 3 cycles -> rx_busy rises then falls, rx_valid stays 0, no flags.
- Frames 0x11 then 0x22 back-to-back with rx_ready=0 -> rx_data=0x11, one rx_overrun pulse. Repeat with rx_ready=1 in the 0x22 completion cycle -> rx_data=0x22, rx_valid stays 1, no overrun.
- Macro defined: a 1-cycle high glitch at count MID of data bit 0 while sending 0x00 -> rx_data=0x00. Macro undefined, same stimulus -> rx_data=0x01. Reset asserted mid-DATA -> all outputs 0, the next clean frame is received correctly.

Source files
------------

// File: rtl/uart_rx_ext_if.sv
// Receive-side character interface of uart_rx_ext.
// Ports (signals):
//   rx_data       [DATA_BITS-1:0]  received character, valid while rx_valid=1
//   rx_valid                       character available, held until accepted
//   rx_ready                       consumer accepts on rx_valid && rx_ready
//   rx_parity_err                  parity mismatch of the character in rx_data
//   rx_frame_err                   a stop bit was sampled low for rx_data
//   rx_overrun                     one-cycle pulse: a completed character was dropped
// Modports: master = receiver (drives the character), slave = consumer.
interface uart_rx_ext_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_parity_err;
    logic                 rx_frame_err;
    logic                 rx_overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_parity_err,
        output rx_frame_err,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: 2-flop synchroniser, start-bit qualification,
// LSB-first data, optional odd/even parity, 1 or 2 stop bits, and a
// valid/ready character output with parity/framing flags and overrun pulse.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous active-high reset
//   rx       asynchronous serial line, idle high
//   rx_busy  frame reception in progress
//   rx_if    uart_rx_ext_if.master character output
// Build option: define UART_RX_MAJORITY_EN to decide each bit by a 2-of-3
// majority of samples around mid-bit (decision one count later); otherwise a
// single mid-bit sample is used.
module uart_rx_ext #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rx,
    output logic          rx_busy,
    uart_rx_ext_if.master rx_if
);

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned MID          = CLKS_PER_BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int unsigned DEC          = MID + 1;
`else
    localparam int unsigned DEC          = MID;
`endif

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_DEC   = CNT_W'(DEC);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 sync1_q, sync2_q;
    logic                 rx_s;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_pend_q, perr_pend_d;
    logic                 ferr_pend_q, ferr_pend_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 perr_q, perr_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;
    logic                 busy_q, busy_d;
`ifdef UART_RX_MAJORITY_EN
    logic                 smp_a_q, smp_a_d;
    logic                 smp_b_q, smp_b_d;
`endif

    logic bit_c;
    logic at_dec_c;
    logic at_last_c;
    logic par_x_c;
    logic par_bad_c;
    logic done_c;

    assign rx_s = sync2_q;

    // Bit decision: majority of the samples at MID-1, MID and the current MID+1,
    // or the plain mid-bit sample.
`ifdef UART_RX_MAJORITY_EN
    assign bit_c = (smp_a_q & smp_b_q) | (smp_a_q & rx_s) | (smp_b_q & rx_s);
`else
    assign bit_c = rx_s;
`endif

    assign at_dec_c  = (cnt_q == CNT_DEC);
    assign at_last_c = (cnt_q == CNT_LAST);

    // Odd parity wants XOR(data, bit)=1, even wants 0.
    assign par_x_c   = (^shift_q) ^ bit_c;
    assign par_bad_c = (PARITY == 1) ? ~par_x_c : par_x_c;

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            shift_q     <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            ovr_q       <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            smp_a_q     <= 1'b1;
            smp_b_q     <= 1'b1;
`endif
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            stop_idx_q  <= stop_idx_d;
            shift_q     <= shift_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            ovr_q       <= ovr_d;
            busy_q      <= busy_d;
`ifdef UART_RX_MAJORITY_EN
            smp_a_q     <= smp_a_d;
            smp_b_q     <= smp_b_d;
`endif
        end
    end

    // Next-state, frame assembly and output handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        stop_idx_d  = stop_idx_q;
        shift_d     = shift_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;
        ovr_d       = 1'b0;
        done_c      = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        smp_a_d     = (cnt_q == CNT_W'(MID - 1)) ? rx_s : smp_a_q;
        smp_b_d     = (cnt_q == CNT_W'(MID))     ? rx_s : smp_b_q;
`endif

        // Bit-period counter; every non-idle state runs 0..CLKS_PER_BIT-1.
        if (state_q != S_IDLE) begin
            cnt_d = at_last_c ? '0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // The cycle that sees the low line is count 0 of the start bit.
                if (!rx_s) begin
                    state_d     = S_START;
                    cnt_d       = 16'd1;
                    bit_idx_d   = '0;
                    stop_idx_d  = 1'b0;
                    perr_pend_d = 1'b0;
                    ferr_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (at_dec_c && bit_c) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (at_last_c) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                end
            end
            S_DATA: begin
                // LSB arrives first, so shifting in from the top lands it at bit 0.
                if (at_dec_c) begin
                    shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
                end
                if (at_last_c) begin
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (at_dec_c && par_bad_c) begin
                    perr_pend_d = 1'b1;
                end
                if (at_last_c) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (at_dec_c) begin
                    if (!bit_c) begin
                        ferr_pend_d = 1'b1;
                    end
                    // Leave at mid-stop so the next start edge is not missed.
                    if (stop_idx_q == STOP_LAST) begin
                        done_c  = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end
                end else if (at_last_c) begin
                    stop_idx_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // A completion either lands in the output register or is dropped.
        if (done_c) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shift_q;
                perr_d  = perr_pend_q;
                ferr_d  = ferr_pend_q | ~bit_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign rx_if.rx_data       = data_q;
    assign rx_if.rx_valid      = valid_q;
    assign rx_if.rx_parity_err = perr_q;
    assign rx_if.rx_frame_err  = ferr_q;
    assign rx_if.rx_overrun    = ovr_q;
    assign rx_busy             = busy_q;

endmodule
